// File: rtl/cm_sweep_checker.sv
// Sweeps all eight {A,B,C} vectors into a 3-input function under test and
// checks each settled output against a golden truth table.
module cm_sweep_checker #(
  parameter logic [7:0]  GOLDEN = 8'hD0,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] err_mask
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [2:0] idx, idx_n, vec, vec_n;
  logic [3:0] cnt, cnt_n, err_count_n;
  logic [7:0] err_mask_n;
  logic       busy_n, done_n, pass_n, miss;

  assign {a_o, b_o, c_o} = vec;
  assign miss = dut_out ^ GOLDEN[idx];

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    vec_n       = vec;
    cnt_n       = cnt;
    err_count_n = err_count;
    err_mask_n  = err_mask;
    busy_n      = busy;
    done_n      = 1'b0;
    pass_n      = pass;
    case (state)
      ST_IDLE: if (start) begin
        state_n     = ST_WAIT;
        idx_n       = 3'd0;
        vec_n       = 3'd0;
        cnt_n       = CNT_INIT;
        err_count_n = 4'd0;
        err_mask_n  = 8'd0;
        pass_n      = 1'b0;
        busy_n      = 1'b1;
      end
      ST_WAIT: begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (miss) begin
          err_mask_n[idx] = 1'b1;
          err_count_n     = err_count + 4'd1;
        end
        if (idx != 3'd7) begin
          idx_n   = idx + 3'd1;
          vec_n   = idx + 3'd1;
          cnt_n   = CNT_INIT;
          state_n = ST_WAIT;
        end else begin
          // pass must include the verdict of this final sample
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_count_n == 4'd0);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      vec       <= 3'd0;
      cnt       <= 4'd0;
      err_count <= 4'd0;
      err_mask  <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      vec       <= vec_n;
      cnt       <= cnt_n;
      err_count <= err_count_n;
      err_mask  <= err_mask_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

endmodule
